// File: rtl/code_sender_pkg.sv
// rtl/code_sender_pkg.sv - shared types, symbol constants and helpers for code_sender
package code_sender_pkg;

    typedef enum logic [1:0] {
        CS_IDLE  = 2'd0,
        CS_PRESS = 2'd1,
        CS_GAP   = 2'd2,
        CS_WAIT  = 2'd3
    } cs_state_t;

    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_A    = 2'b01;
    localparam logic [1:0] SYM_B    = 2'b10;
    localparam logic [1:0] SYM_C    = 2'b11;

    localparam int CODE_LEN = 3;

    // Symbol 0 sits in the low bits and is sent first.
    localparam logic [2*CODE_LEN-1:0] DEFAULT_CODE = {SYM_B, SYM_A, SYM_A};

    // Counter width for a cycle count n: $clog2(n), never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Pick symbol idx out of a packed code word.
    function automatic logic [1:0] sym_at(input logic [2*CODE_LEN-1:0] code,
                                          input logic [1:0]            idx);
        case (idx)
            2'd0:    sym_at = code[1:0];
            2'd1:    sym_at = code[3:2];
            default: sym_at = code[5:4];
        endcase
    endfunction

endpackage

// File: rtl/code_sender_timer.sv
// rtl/code_sender_timer.sv - loadable saturating down-counter with zero flag
module code_sender_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over decrement; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/code_sender.sv
// rtl/code_sender.sv - lock code transmitter with result check; CODE_SENDER_PROG_EN adds code_i
module code_sender
    import code_sender_pkg::*;
#(
    parameter int HOLD_CYCLES    = 1,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  unlock_i,
`ifdef CODE_SENDER_PROG_EN
    input  logic [2*CODE_LEN-1:0] code_i,
`endif
    output logic                  a_o,
    output logic                  b_o,
    output logic                  c_o,
    output logic                  busy,
    output logic                  done,
    output logic                  success
);

    localparam int PW = (cnt_width(HOLD_CYCLES) > cnt_width(GAP_CYCLES)) ?
                        cnt_width(HOLD_CYCLES) : cnt_width(GAP_CYCLES);
    localparam int TW = cnt_width(TIMEOUT_CYCLES);

    // Timers count N-1 down to zero, so zero marks the last cycle of a phase.
    localparam logic [PW-1:0] HOLD_LOAD = PW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] GAP_LOAD  = PW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    LAST_IDX  = 2'(CODE_LEN - 1);

    cs_state_t             state, state_nxt;
    logic [1:0]            idx, idx_nxt;
    logic [2*CODE_LEN-1:0] code_nxt;
    logic [1:0]            sym_nxt;
    logic                  ph_load, ph_dec, ph_zero;
    logic [PW-1:0]         ph_val;
    logic                  to_load, to_dec, to_zero;
    logic                  accept, finish, win;

`ifdef CODE_SENDER_PROG_EN
    logic [2*CODE_LEN-1:0] code_q;

    // Capture the code once per attempt so later code_i changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q <= DEFAULT_CODE;
        end else if (accept) begin
            code_q <= code_i;
        end
    end

    assign code_nxt = accept ? code_i : code_q;
`else
    assign code_nxt = DEFAULT_CODE;
`endif

    code_sender_timer #(.W(PW)) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load),
        .load_val (ph_val),
        .dec      (ph_dec),
        .zero     (ph_zero)
    );

    code_sender_timer #(.W(TW)) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (to_load),
        .load_val (TO_LOAD),
        .dec      (to_dec),
        .zero     (to_zero)
    );

    // Next-state and timer control; a start coinciding with done is refused.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ph_load   = 1'b0;
        ph_val    = HOLD_LOAD;
        ph_dec    = 1'b0;
        to_load   = 1'b0;
        to_dec    = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        win       = 1'b0;
        case (state)
            CS_IDLE: begin
                if (start && !done) begin
                    accept    = 1'b1;
                    state_nxt = CS_PRESS;
                    idx_nxt   = 2'd0;
                    ph_load   = 1'b1;
                    ph_val    = HOLD_LOAD;
                end
            end
            CS_PRESS: begin
                if (!ph_zero) begin
                    ph_dec = 1'b1;
                end else if (idx < LAST_IDX) begin
                    state_nxt = CS_GAP;
                    ph_load   = 1'b1;
                    ph_val    = GAP_LOAD;
                end else begin
                    state_nxt = CS_WAIT;
                    to_load   = 1'b1;
                end
            end
            CS_GAP: begin
                if (!ph_zero) begin
                    ph_dec = 1'b1;
                end else begin
                    state_nxt = CS_PRESS;
                    idx_nxt   = idx + 2'd1;
                    ph_load   = 1'b1;
                    ph_val    = HOLD_LOAD;
                end
            end
            CS_WAIT: begin
                if (unlock_i) begin
                    finish    = 1'b1;
                    win       = 1'b1;
                    state_nxt = CS_IDLE;
                end else if (to_zero) begin
                    finish    = 1'b1;
                    state_nxt = CS_IDLE;
                end else begin
                    to_dec = 1'b1;
                end
            end
            default: state_nxt = CS_IDLE;
        endcase
    end

    assign sym_nxt = sym_at(code_nxt, idx_nxt);

    // State plus registered outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CS_IDLE;
            idx     <= 2'd0;
            a_o     <= 1'b0;
            b_o     <= 1'b0;
            c_o     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            success <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            a_o   <= (state_nxt == CS_PRESS) && (sym_nxt == SYM_A);
            b_o   <= (state_nxt == CS_PRESS) && (sym_nxt == SYM_B);
            c_o   <= (state_nxt == CS_PRESS) && (sym_nxt == SYM_C);
            busy  <= (state_nxt != CS_IDLE);
            done  <= finish;
            if (accept) begin
                success <= 1'b0;
            end else if (finish) begin
                success <= win;
            end
        end
    end

endmodule
